// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN core image-loading path.
//   NUM_PIXELS     : pixels per image (multiple of BYTE_WIDTH)
//   BYTE_WIDTH     : bits per UART byte
//   ADDR_WIDTH     : input-pixel RAM address width
//   loader_state_t : uart_pixel_loader FSM states
package snn_pkg;
    localparam int NUM_PIXELS = 784;
    localparam int BYTE_WIDTH = 8;
    localparam int ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } loader_state_t;
endpackage

// File: rtl/pixel_unpacker.sv
// Byte holding register that is unloaded one bit per shift, LSB first.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture data and restart the bit counter
//   data     : byte to capture
//   shift    : shift right by one; bit0 presents the next pixel
//   bit0     : current pixel (LSB of the holding register)
//   done     : high on the shift that consumes the last bit of the byte
module pixel_unpacker #(
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BYTE_WIDTH-1:0] data,
    input  logic                  shift,
    output logic                  bit0,
    output logic                  done
);
    localparam int CW = $clog2(BYTE_WIDTH);

    logic [BYTE_WIDTH-1:0] sreg;
    logic [CW-1:0]         bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sreg    <= data;
            bit_cnt <= '0;
        end else if (shift) begin
            sreg    <= sreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign bit0 = sreg[0];
    assign done = shift && (bit_cnt == CW'(BYTE_WIDTH - 1));
endmodule

// File: rtl/uart_pixel_loader.sv
// Unpacks UART bytes into 1-bit pixels and writes them to the input-pixel RAM.
// After NUM_PIXELS pixels it raises img_rdy and ignores bytes until core_done.
//   clk, rst   : clock, asynchronous active-high reset
//   rx_rdy     : one-cycle pulse, rx_data valid
//   rx_data    : received byte (bit i of byte k -> pixel BYTE_WIDTH*k+i)
//   ram_we     : RAM write enable, ram_addr/ram_data: write address/pixel
//   img_rdy    : full image resident in RAM (level)
//   core_done  : one-cycle pulse from inference core, honoured only in FULL
//   busy       : loader not in IDLE
//   overrun    : sticky dropped-byte flag; only built when the macro
//                PIXEL_LOADER_OVERRUN_EN is defined, otherwise tied to 0
module uart_pixel_loader
    import snn_pkg::*;
#(
    parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,
    parameter int ADDR_WIDTH = snn_pkg::ADDR_WIDTH,
    parameter int BYTE_WIDTH = snn_pkg::BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_data,
    output logic                  img_rdy,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  overrun
);
    loader_state_t         state, state_nx;
    logic [ADDR_WIDTH-1:0] pixel_cnt;
    logic                  load, shift, byte_done;
    logic                  we_q, busy_q, img_rdy_q;

    pixel_unpacker #(.BYTE_WIDTH(BYTE_WIDTH)) u_unpack (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (rx_data),
        .shift (shift),
        .bit0  (ram_data),
        .done  (byte_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    load     = 1'b1;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                shift = 1'b1;
                // pixel_cnt still holds the address being written this cycle
                if (byte_done)
                    state_nx = (pixel_cnt == ADDR_WIDTH'(NUM_PIXELS - 1)) ? FULL : IDLE;
            end
            FULL: begin
                if (core_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           pixel_cnt <= '0;
        else if (state == WRITE)           pixel_cnt <= pixel_cnt + 1'b1;
        else if (state == FULL && core_done) pixel_cnt <= '0;
    end

    // Status flags are flopped from the next state so they line up with the
    // state register while still coming straight out of flip-flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            img_rdy_q <= 1'b0;
        end else begin
            we_q      <= (state_nx == WRITE);
            busy_q    <= (state_nx != IDLE);
            img_rdy_q <= (state_nx == FULL);
        end
    end

    assign ram_we   = we_q;
    assign ram_addr = pixel_cnt;
    assign busy     = busy_q;
    assign img_rdy  = img_rdy_q;

`ifdef PIXEL_LOADER_OVERRUN_EN
    logic overrun_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            overrun_q <= 1'b0;
        else if (rx_rdy && state != IDLE)   overrun_q <= 1'b1;
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_uart_pixel_loader.sv
// Directed bench for uart_pixel_loader. Bytes are spaced 12 cycles apart
// instead of a real UART period to keep the run short; spacing only needs to
// exceed the 9-cycle byte processing window.
module tb_uart_pixel_loader;
    localparam int NP = 784;
`ifdef PIXEL_LOADER_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       core_done = 1'b0;
    logic       ram_we, ram_data, img_rdy, busy, overrun;
    logic [9:0] ram_addr;

    int errors = 0;
    int checks = 0;

    logic mem [NP];
    int   wr_cnt = 0;

    uart_pixel_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .img_rdy   (img_rdy),
        .core_done (core_done),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // RAM model: one write per cycle with ram_we high, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && ram_we) begin
            if (int'(ram_addr) < NP) mem[ram_addr] = ram_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int seed, input int k);
        return 8'((k * 37 + seed * 11 + 5) ^ (k >> 2));
    endfunction

    task automatic do_reset();
        rst = 1'b1; rx_rdy = 1'b0; core_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (11) tick();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NP; i++) mem[i] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ram_we, ram_addr, ram_data, img_rdy, busy, overrun} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {ram_we, ram_addr, ram_data, img_rdy, busy, overrun});
        end
    endtask

    task automatic test_single_byte();
        logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int bad = 0;
        do_reset();
        rx_data = 8'hA5; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ram_we !== 1'b1 || ram_addr !== 10'(i) || ram_data !== exp_bits[i] ||
                busy !== 1'b1 || img_rdy !== 1'b0) begin
                bad++;
                $display("FAIL a5_write%0d: we=%b addr=%0d data=%b busy=%b img=%b expected 1 %0d %b 1 0",
                         i, ram_we, ram_addr, ram_data, busy, img_rdy, i, exp_bits[i]);
            end
            tick();
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if ({ram_we, busy, img_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL a5_after: we/busy/img=%b expected 000", {ram_we, busy, img_rdy});
        end
    endtask

    // Loads a whole image; checks img_rdy edge timing and RAM contents
    task automatic test_full_image(input int seed, input string tag);
        int bad = 0;
        int w0;
        logic [7:0] b;
        clear_mem();
        w0 = wr_cnt;
        for (int k = 0; k < 97; k++) send_byte(pat(seed, k));
        rx_data = pat(seed, 97); rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (7) tick();
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== 10'd783 || img_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s_t8: we=%b addr=%0d img=%b expected 1 783 0", tag, ram_we, ram_addr, img_rdy);
        end
        tick();
        checks++;
        if (img_rdy !== 1'b1 || ram_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_t9: img=%b we=%b busy=%b expected 1 0 1", tag, img_rdy, ram_we, busy);
        end
        for (int k = 0; k < 98; k++) begin
            b = pat(seed, k);
            for (int i = 0; i < 8; i++) if (mem[8*k+i] !== b[i]) bad++;
        end
        checks++;
        if (bad != 0 || wr_cnt - w0 != NP) begin
            errors++;
            $display("FAIL %s_ram: bad_bits=%0d writes=%0d expected 0 %0d", tag, bad, wr_cnt - w0, NP);
        end
    endtask

    task automatic test_full_state();
        int w0;
        int bad = 0;
        logic [7:0] b = 8'h3C;
        w0 = wr_cnt;
        rx_data = 8'hFF; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (10) tick();
        checks++;
        if (wr_cnt != w0 || img_rdy !== 1'b1 || overrun !== OVR_EN) begin
            errors++;
            $display("FAIL full_drop: writes=%0d img=%b ovr=%b expected 0 1 %b", wr_cnt - w0, img_rdy, overrun, OVR_EN);
        end
        // core_done together with a byte: core_done wins, byte dropped
        core_done = 1'b1; rx_rdy = 1'b1; rx_data = 8'h81;
        tick();
        core_done = 1'b0; rx_rdy = 1'b0;
        checks++;
        if ({img_rdy, busy, ram_we} !== 3'b000) begin
            errors++;
            $display("FAIL full_release: img/busy/we=%b expected 000", {img_rdy, busy, ram_we});
        end
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 1'b1;
        w0 = wr_cnt;
        send_byte(b);
        for (int i = 0; i < 8; i++) if (mem[i] !== b[i]) bad++;
        checks++;
        if (bad != 0 || wr_cnt - w0 != 8) begin
            errors++;
            $display("FAIL full_next_byte: bad_bits=%0d writes=%0d expected 0 8", bad, wr_cnt - w0);
        end
    endtask

    task automatic test_write_overrun();
        int bad = 0;
        logic [7:0] b0 = 8'h96;
        logic [7:0] b1 = 8'h01;
        do_reset();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_cleared: got %b expected 0", overrun);
        end
        clear_mem();
        rx_data = b0; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (3) tick();
        rx_data = 8'hFF; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (8) tick();
        checks++;
        if (busy !== 1'b0 || overrun !== OVR_EN) begin
            errors++;
            $display("FAIL ovr_write: busy=%b ovr=%b expected 0 %b", busy, overrun, OVR_EN);
        end
        send_byte(b1);
        for (int i = 0; i < 8; i++) begin
            if (mem[i] !== b0[i]) bad++;
            if (mem[8+i] !== b1[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ovr_data: bad_bits=%0d expected 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 50; k++) send_byte(pat(3, k));
        rx_data = 8'hFF; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ram_we, ram_addr, ram_data, img_rdy, busy, overrun} !== 15'd0) begin
            errors++;
            $display("FAIL midreset_async: got %b expected 0", {ram_we, ram_addr, ram_data, img_rdy, busy, overrun});
        end
        tick();
        rst = 1'b0;
        tick();
        test_full_image(9, "midreset_reload");
    endtask

    task automatic test_core_done_ignored();
        int bad = 0;
        logic [7:0] b0 = 8'hC3;
        logic [7:0] b1 = 8'h5A;
        do_reset();
        clear_mem();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL cd_idle: busy=%b we=%b expected 0 0", busy, ram_we);
        end
        send_byte(b0);
        rx_data = b1; rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b1 || ram_addr !== 10'd10) begin
            errors++;
            $display("FAIL cd_write: busy=%b addr=%0d expected 1 10", busy, ram_addr);
        end
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            if (mem[i] !== b0[i]) bad++;
            if (mem[8+i] !== b1[i]) bad++;
        end
        checks++;
        if (bad != 0 || img_rdy !== 1'b0) begin
            errors++;
            $display("FAIL cd_data: bad_bits=%0d img=%b expected 0 0", bad, img_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        do_reset();
        test_full_image(1, "image");
        test_full_state();
        test_write_overrun();
        test_mid_reset();
        test_core_done_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
